// File: rtl/mem_server_pkg.sv
// Shared encodings and byte-lane helpers for the MemIntf SRAM server.
// Out-of-bounds read data exists only when MEM_SERVER_OOB_CHECK_EN is defined.
package mem_server_pkg;

    localparam logic       OP_READ  = 1'b0;
    localparam logic       OP_WRITE = 1'b1;

    localparam logic [1:0] LEN_WORD = 2'd0;
    localparam logic [1:0] LEN_BYTE = 2'd1;
    localparam logic [1:0] LEN_HALF = 2'd2;
    localparam logic [1:0] LEN_RSVD = 2'd3;

    // Response payload bits excluding the opaque tag: op + addr + len + data.
    localparam int unsigned MSG_FIXED_BITS = 67;

`ifdef MEM_SERVER_OOB_CHECK_EN
    localparam logic [31:0] OOB_DATA = 32'hDEAD_BEEF;
`endif

    function automatic logic [3:0] len_mask(input logic [1:0] len);
        logic [3:0] m;
        m = 4'b1111;
        unique case (len)
            LEN_BYTE:           m = 4'b0001;
            LEN_HALF:           m = 4'b0011;
            LEN_WORD, LEN_RSVD: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Lanes shifted past byte 3 fall off the word.
    function automatic logic [3:0] wr_strb(input logic [1:0] len, input logic [1:0] off);
        logic [7:0] wide;
        wide = {4'b0000, len_mask(len)} << off;
        return wide[3:0];
    endfunction

    function automatic logic [31:0] wr_align(input logic [31:0] data, input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

    function automatic logic [31:0] rd_extract(input logic [31:0] word, input logic [1:0] len,
                                               input logic [1:0] off);
        logic [31:0] shifted;
        logic [31:0] keep;
        logic [3:0]  m;
        shifted = word >> {off, 3'b000};
        m       = len_mask(len);
        for (int b = 0; b < 4; b++) begin
            keep[8*b +: 8] = {8{m[b]}};
        end
        return shifted & keep;
    endfunction

endpackage

// File: rtl/mem_intf_sram_server_if.sv
// MemIntf request/response channel pair; master drives requests, slave answers.
interface mem_intf_sram_server_if #(
    parameter int unsigned p_opaq_bits = 8
);

    typedef struct packed {
        logic                   op;
        logic [p_opaq_bits-1:0] opaque;
        logic [31:0]            addr;
        logic [1:0]             len;
        logic [31:0]            data;
    } req_t;

    typedef struct packed {
        logic                   op;
        logic [p_opaq_bits-1:0] opaque;
        logic [31:0]            addr;
        logic [1:0]             len;
        logic [31:0]            data;
    } resp_t;

    logic  req_val;
    logic  req_rdy;
    req_t  req_msg;
    logic  resp_val;
    logic  resp_rdy;
    resp_t resp_msg;

    modport master (output req_val, req_msg, resp_rdy, input req_rdy, resp_val, resp_msg);
    modport slave  (input req_val, req_msg, resp_rdy, output req_rdy, resp_val, resp_msg);

endinterface

// File: rtl/mem_server_resp_queue.sv
// Valid/ready response FIFO; head payload reads as zero while empty.
module mem_server_resp_queue #(
    parameter int unsigned p_depth = 2,
    parameter int unsigned p_width = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enq_val_i,
    input  logic [p_width-1:0]           enq_msg_i,
    output logic                         deq_val_o,
    input  logic                         deq_rdy_i,
    output logic [p_width-1:0]           deq_msg_o,
    output logic [$clog2(p_depth+1)-1:0] occ_o
);

    localparam int unsigned PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int unsigned OCC_W = $clog2(p_depth + 1);

    logic [p_width-1:0] slot_q [p_depth];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]   cnt_q, cnt_d;
    logic               enq_c, deq_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(p_depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        deq_c    = (cnt_q != '0) && deq_rdy_i;
        enq_c    = enq_val_i && ((cnt_q != OCC_W'(p_depth)) || deq_c);
        rd_ptr_d = deq_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = enq_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        cnt_d    = cnt_q + OCC_W'(enq_c) - OCC_W'(deq_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (enq_c) begin
            slot_q[wr_ptr_q] <= enq_msg_i;
        end
    end

    assign deq_val_o = (cnt_q != '0);
    assign deq_msg_o = deq_val_o ? slot_q[rd_ptr_q] : '0;
    assign occ_o     = cnt_q;

endmodule

// File: rtl/mem_intf_sram_server.sv
// MemIntf SRAM responder: one-cycle stage register feeding an in-order response queue.
// Define MEM_SERVER_OOB_CHECK_EN to flag out-of-range addresses instead of wrapping.
module mem_intf_sram_server
    import mem_server_pkg::*;
#(
    parameter int unsigned p_opaq_bits  = 8,
    parameter int unsigned p_mem_words  = 1024,
    parameter int unsigned p_resp_depth = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_intf_sram_server_if.slave  mif
);

    localparam int unsigned IDX_W = $clog2(p_mem_words);
    localparam int unsigned MSG_W = p_opaq_bits + MSG_FIXED_BITS;
    localparam int unsigned OCC_W = $clog2(p_resp_depth + 1);
    localparam int unsigned TOT_W = OCC_W + 1;

    logic [31:0]      sram [p_mem_words];
    logic             live_q, live_d;
    logic             s1_val_q, s1_val_d;
    logic [MSG_W-1:0] s1_msg_q, s1_msg_d;
    logic [OCC_W-1:0] q_occ;
    logic             q_val;
    logic [MSG_W-1:0] q_msg;
    logic [TOT_W-1:0] outstanding_c;
    logic             rdy_c, acc_c, oob_c;
    logic [IDX_W-1:0] idx_c;
    logic [1:0]       off_c;
    logic [3:0]       we_c;
    logic [31:0]      wdata_c, rdata_c;

    // Credit check: a response leaving this cycle frees its slot for the next accept.
    always_comb begin
        outstanding_c = TOT_W'(q_occ) + TOT_W'(s1_val_q) - TOT_W'(q_val && mif.resp_rdy);
        rdy_c         = live_q && (outstanding_c < TOT_W'(p_resp_depth));
    end

    assign mif.req_rdy = rdy_c;
    assign acc_c       = mif.req_val && rdy_c;

    always_comb begin
        idx_c   = mif.req_msg.addr[IDX_W+1:2];
        off_c   = mif.req_msg.addr[1:0];
`ifdef MEM_SERVER_OOB_CHECK_EN
        oob_c   = |mif.req_msg.addr[31:IDX_W+2];
`else
        oob_c   = 1'b0;
`endif
        we_c    = '0;
        wdata_c = wr_align(mif.req_msg.data, off_c);
        rdata_c = '0;
        if (acc_c && (mif.req_msg.op == OP_WRITE) && !oob_c) begin
            we_c = wr_strb(mif.req_msg.len, off_c);
        end
        if (mif.req_msg.op == OP_READ) begin
`ifdef MEM_SERVER_OOB_CHECK_EN
            rdata_c = oob_c ? OOB_DATA : rd_extract(sram[idx_c], mif.req_msg.len, off_c);
`else
            rdata_c = rd_extract(sram[idx_c], mif.req_msg.len, off_c);
`endif
        end
        live_d   = 1'b1;
        s1_val_d = acc_c;
        s1_msg_d = s1_msg_q;
        if (acc_c) begin
            s1_msg_d = {mif.req_msg.op, mif.req_msg.opaque, mif.req_msg.addr,
                        mif.req_msg.len, rdata_c};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q   <= 1'b0;
            s1_val_q <= 1'b0;
            s1_msg_q <= '0;
        end else begin
            live_q   <= live_d;
            s1_val_q <= s1_val_d;
            s1_msg_q <= s1_msg_d;
        end
    end

    // Byte-enabled SRAM; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_c[b]) begin
                sram[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
            end
        end
    end

    mem_server_resp_queue #(
        .p_depth (p_resp_depth),
        .p_width (MSG_W)
    ) u_resp_queue (
        .clk       (clk),
        .rst       (rst),
        .enq_val_i (s1_val_q),
        .enq_msg_i (s1_msg_q),
        .deq_val_o (q_val),
        .deq_rdy_i (mif.resp_rdy),
        .deq_msg_o (q_msg),
        .occ_o     (q_occ)
    );

    assign mif.resp_val = q_val;
    assign mif.resp_msg = q_msg;

endmodule

// File: doc/mem_intf_sram_server.md
# mem_intf_sram_server

Synthesizable single-port memory responder for the `MemIntf` request/response protocol: accepts read/write requests from an initiator (e.g. a BlimpV5 instruction or data port), performs them on an on-chip word-organized SRAM, and returns in-order responses carrying the original opaque tag. It sits below the core in FPGA and tapeout builds, replacing the behavioural test memory server.

## Interface
Parameters:
- p_opaq_bits, 8, width of the opaque tag echoed in responses
- p_mem_words, 1024, SRAM depth in 32-bit words (power of two, ≥ 4)
- p_resp_depth, 2, response queue entries (≥ 1; ≥ 2 required for full throughput)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- req_msg  in  `MEM_REQ(p_opaq_bits)`  request: op, opaque, addr[31:0], len[1:0], data[31:0]
- resp_val  out  1  response valid
- resp_rdy  in  1  response ready
- resp_msg  out  `MEM_RESP(p_opaq_bits)`  response: op, opaque, addr, len, data[31:0]

## Operation
- Request fires when req_val && req_rdy; response fires when resp_val && resp_rdy.
- Word index = addr[log2(p_mem_words)+1:2]; byte offset = addr[1:0].
- len: 0 = word, 1 = byte, 2 = halfword, 3 = reserved (treated as word).
- Read: data = SRAM word shifted right by 8×offset, zero-extended to len size.
- Write: byte strobes derived from len and offset; write data taken from low bytes of req data, shifted left by 8×offset; bytes beyond bit 31 dropped. Response data = 0.
- Write commits in the acceptance cycle; a read accepted in the next cycle to the same word returns the new value (no hazard).
- Response echoes op, opaque, addr, len unchanged; responses strictly in request order.
- Stage 1 register holds in-flight response; queue of p_resp_depth entries behind it.
- req_rdy = (queue occupancy + in-flight) < p_resp_depth; never depends combinationally on req_val.
- Reset: req_rdy = 0, resp_val = 0, resp_msg = 0, queue and in-flight cleared; SRAM contents undefined (not reset). Reset asserted mid-transaction discards all pending responses.

## Timing
- Latency: request accepted at edge N → resp_val at earliest after edge N+1.
- Throughput: 1 request/cycle with resp_rdy held high and p_resp_depth ≥ 2.
- resp_rdy low: queue fills; req_rdy drops once in-flight + occupancy = p_resp_depth; resp_msg stable while resp_val && !resp_rdy.
- Simultaneous enqueue and dequeue on full queue: allowed only via in-flight accounting; occupancy unchanged.
- req_rdy rises the first cycle after rst deasserts.

## Configuration
- `MEM_SERVER_OOB_CHECK_EN` defined: word index ≥ p_mem_words or addr[31:log2(p_mem_words)+2] ≠ 0 flags out-of-bounds; reads return 32'hDEADBEEF, writes dropped, response still issued.
- Undefined: upper address bits ignored; addresses wrap modulo p_mem_words×4.

## Structure
- Shared package `mem_server_pkg`: op encodings (READ = 0, WRITE = 1), len encodings, strobe/shift helper functions.
- One sub-module: `mem_server_resp_queue` (parameterized depth, valid/ready FIFO, occupancy output).
- SRAM inferred in the top as a per-byte write-enabled array.

## Test plan
- Reset: rst low 3 cycles → req_rdy = 0, resp_val = 0; req_rdy = 1 first cycle after release.
- Write word 0x12345678 to 0x100, read 0x100 → response data 0x12345678, opaque echoed (e.g. 0x5A), write response data 0.
- Byte write 0xAB to 0x103 over 0x00000000, read byte 0x103 → 0x000000AB, read word 0x100 → 0xAB000000.
- 8 back-to-back reads, resp_rdy = 1 → 8 responses in order on consecutive cycles; resp_rdy held 0 for 4 cycles → req_rdy drops after 2 accepts, no response lost.
- Reset asserted with 2 responses pending → resp_val = 0 immediately, no stale responses after release.
- OOB with macro, p_mem_words = 1024: read 0x1000 → 0xDEADBEEF; without macro: read 0x1000 returns word at 0x0000.
